// File: rtl/snake_step_ctrl_if.sv
// -----------------------------------------------------------------------------
// snake_step_ctrl_if
//
// Body-RAM bus between the snake step sequencer and its external single-port
// body RAM. The RAM is synchronous-read: ram_rdata carries the word addressed
// by ram_addr one clock later.
//
// Signals:
//   ram_addr   body RAM address (driven by master)
//   ram_we     write enable (driven by master)
//   ram_wdata  write data {x[7:0], y[7:0]} (driven by master)
//   ram_rdata  read data {x[7:0], y[7:0]} (driven by slave / RAM)
//
// Modports:
//   master  the step sequencer
//   slave   the body RAM
// -----------------------------------------------------------------------------
interface snake_step_ctrl_if #(
  parameter int PTR_W = 6
);
  logic [PTR_W-1:0] ram_addr;
  logic             ram_we;
  logic [15:0]      ram_wdata;
  logic [15:0]      ram_rdata;

  modport master (
    output ram_addr,
    output ram_we,
    output ram_wdata,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr,
    input  ram_we,
    input  ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/snake_step_ctrl.sv
// -----------------------------------------------------------------------------
// snake_step_ctrl
//
// Multi-cycle step sequencer for the snake game. The snake body is a circular
// buffer of {x,y} cells in an external single-port RAM; segments live at
// tail_ptr..head_ptr (modulo BODYMAX). On every accepted step_tick the block
// computes the next head cell, scans the body for a self-collision one RAM
// word per cycle, checks for food, and then writes the new head while either
// growing (tail held) or advancing the tail.
//
// Optional feature (compile-time macro):
//   SNAKE_WRAP_EN  defined   : moving off an edge wraps to the opposite edge.
//                  undefined : moving off an edge kills the snake at once.
//
// Parameters:
//   COLS, ROWS  playfield size (cells)
//   BODYMAX     body RAM depth / maximum length (power of two)
//   PTR_W       log2(BODYMAX)
//
// Ports:
//   VGA_CLK       sole clock
//   RST_N         asynchronous active-low reset
//   run_en        game enable level; low forces re-initialisation
//   step_tick     one-cycle step request (dropped while busy)
//   dir           0=+x 1=+y 2=-x 3=-y, sampled when a tick is accepted
//   food_x/_y     food cell, food_valid qualifies it
//   ram           body RAM bus (master side, all outputs registered)
//   head_x/_y     current head cell
//   length        segment count, 1..BODYMAX
//   tail_ptr      buffer pointer of the oldest segment
//   head_ptr      buffer pointer of the head segment
//   food_eaten    one-cycle pulse during the head write of an eating step
//   dead          sticky collision flag
//   busy          high in INIT/SCAN/WRITE
//   tick_overrun  sticky; a tick arrived while busy; cleared in INIT
// -----------------------------------------------------------------------------
module snake_step_ctrl #(
  parameter int COLS    = 80,
  parameter int ROWS    = 60,
  parameter int BODYMAX = 64,
  parameter int PTR_W   = 6
) (
  input  logic                    VGA_CLK,
  input  logic                    RST_N,
  input  logic                    run_en,
  input  logic                    step_tick,
  input  logic [1:0]              dir,
  input  logic [7:0]              food_x,
  input  logic [7:0]              food_y,
  input  logic                    food_valid,
  snake_step_ctrl_if.master       ram,
  output logic [7:0]              head_x,
  output logic [7:0]              head_y,
  output logic [PTR_W:0]          length,
  output logic [PTR_W-1:0]        tail_ptr,
  output logic [PTR_W-1:0]        head_ptr,
  output logic                    food_eaten,
  output logic                    dead,
  output logic                    busy,
  output logic                    tick_overrun
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_SCAN  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DEAD  = 3'd4;

  localparam logic [7:0]     HOME_X  = 8'(COLS / 2);
  localparam logic [7:0]     HOME_Y  = 8'(ROWS / 2);
  localparam logic [7:0]     MAX_X   = 8'(COLS - 1);
  localparam logic [7:0]     MAX_Y   = 8'(ROWS - 1);
  localparam logic [PTR_W:0] LEN_MAX = (PTR_W + 1)'(BODYMAX);
  localparam logic [PTR_W:0] LEN_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]       state;
  logic [7:0]       nx, ny;      // latched next head cell for the step
  logic             eat;         // step lands on food
  logic             grow;        // step lengthens the snake
  logic [PTR_W:0]   scan_n;      // body segments to compare this step
  logic [PTR_W:0]   scan_cnt;    // SCAN cycle index, 0..scan_n

  // ---------------------------------------------------------------------------
  // Next-cell candidate from the current head and dir.
  // at_edge flags a move off the playfield; the candidate already holds the
  // wrapped cell, which is only used when wrapping is enabled.
  // ---------------------------------------------------------------------------
  logic [7:0] cand_x, cand_y;
  logic       at_edge;
  logic       edge_kill;
  logic       hit_food;
  logic       can_grow;
  logic       scan_hit;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise the tool infers a latch.
  always_comb begin
    cand_x  = head_x;
    cand_y  = head_y;
    at_edge = 1'b0;
    unique case (dir)
      2'd0: begin
        if (head_x == MAX_X) begin
          at_edge = 1'b1;
          cand_x  = 8'd0;
        end else begin
          cand_x  = head_x + 8'd1;
        end
      end
      2'd1: begin
        if (head_y == MAX_Y) begin
          at_edge = 1'b1;
          cand_y  = 8'd0;
        end else begin
          cand_y  = head_y + 8'd1;
        end
      end
      2'd2: begin
        if (head_x == 8'd0) begin
          at_edge = 1'b1;
          cand_x  = MAX_X;
        end else begin
          cand_x  = head_x - 8'd1;
        end
      end
      2'd3: begin
        if (head_y == 8'd0) begin
          at_edge = 1'b1;
          cand_y  = MAX_Y;
        end else begin
          cand_y  = head_y - 8'd1;
        end
      end
    endcase
  end

  assign edge_kill = at_edge && !WRAP_EN;
  assign hit_food  = food_valid && (cand_x == food_x) && (cand_y == food_y);
  assign can_grow  = (length < LEN_MAX);

  // rdata in SCAN cycle k belongs to the address issued in cycle k-1, so
  // cycle 0 carries a stale word and is masked.
  assign scan_hit  = (scan_cnt != '0) && (ram.ram_rdata == {nx, ny});

  assign busy = (state == ST_INIT) || (state == ST_SCAN) || (state == ST_WRITE);

  // ---------------------------------------------------------------------------
  // Overrun flag: INIT clears it (a tick landing in INIT itself still counts),
  // any tick seen while SCAN/WRITE sets it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_overrun <= 1'b0;
    end else if (state == ST_INIT) begin
      tick_overrun <= step_tick;
    end else if (busy && step_tick) begin
      tick_overrun <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequencer
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the body buffer is an external RAM and is not reset; INIT rewrites
  // address 0 and the pointers make every other word don't-care.
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= ST_INIT;
      ram.ram_addr  <= '0;
      ram.ram_we    <= 1'b0;
      ram.ram_wdata <= '0;
      head_x        <= HOME_X;
      head_y        <= HOME_Y;
      length        <= LEN_ONE;
      tail_ptr      <= '0;
      head_ptr      <= '0;
      food_eaten    <= 1'b0;
      dead          <= 1'b0;
      nx            <= '0;
      ny            <= '0;
      eat           <= 1'b0;
      grow          <= 1'b0;
      scan_n        <= '0;
      scan_cnt      <= '0;
    end else begin
      // Single-cycle pulses by default.
      ram.ram_we <= 1'b0;
      food_eaten <= 1'b0;

      if (!run_en && (state != ST_INIT)) begin
        // Abort whatever is in flight; INIT restores the body next cycle.
        state <= ST_INIT;
      end else begin
        unique case (state)
          ST_INIT: begin
            head_x   <= HOME_X;
            head_y   <= HOME_Y;
            length   <= LEN_ONE;
            tail_ptr <= '0;
            head_ptr <= '0;
            dead     <= 1'b0;
            if (run_en) begin
              ram.ram_we    <= 1'b1;
              ram.ram_addr  <= '0;
              ram.ram_wdata <= {HOME_X, HOME_Y};
              state         <= ST_IDLE;
            end
          end

          ST_IDLE: begin
            if (step_tick) begin
              if (edge_kill) begin
                dead  <= 1'b1;
                state <= ST_DEAD;
              end else begin
                nx       <= cand_x;
                ny       <= cand_y;
                eat      <= hit_food;
                grow     <= hit_food && can_grow;
                scan_cnt <= '0;
                // A non-growing step vacates the tail, so the scan starts one
                // past it and covers tail+1..head; a growing step covers all.
                if (hit_food && can_grow) begin
                  scan_n       <= length;
                  ram.ram_addr <= tail_ptr;
                end else begin
                  scan_n       <= length - LEN_ONE;
                  ram.ram_addr <= tail_ptr + PTR_ONE;
                end
                state <= ST_SCAN;
              end
            end
          end

          ST_SCAN: begin
            if (scan_hit) begin
              dead  <= 1'b1;
              state <= ST_DEAD;
            end else if (scan_cnt == scan_n) begin
              // Present the head write during the WRITE cycle itself.
              ram.ram_we    <= 1'b1;
              ram.ram_addr  <= head_ptr + PTR_ONE;
              ram.ram_wdata <= {nx, ny};
              food_eaten    <= eat;
              state         <= ST_WRITE;
            end else begin
              scan_cnt     <= scan_cnt + LEN_ONE;
              ram.ram_addr <= ram.ram_addr + PTR_ONE;
            end
          end

          ST_WRITE: begin
            head_ptr <= head_ptr + PTR_ONE;
            head_x   <= nx;
            head_y   <= ny;
            if (grow) begin
              length <= length + LEN_ONE;
            end else begin
              tail_ptr <= tail_ptr + PTR_ONE;
            end
            state <= ST_IDLE;
          end

          ST_DEAD: begin
            state <= ST_DEAD;
          end

          default: begin
            state <= ST_INIT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snake_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snake_step_ctrl
//
// Directed bench for snake_step_ctrl with a behavioural synchronous-read body
// RAM. Expected values are hand-computed from the playfield geometry.
// -----------------------------------------------------------------------------
module tb_snake_step_ctrl;

  localparam int PTR_W = 6;

  logic             VGA_CLK = 1'b0;
  logic             RST_N;
  logic             run_en;
  logic             step_tick;
  logic [1:0]       dir;
  logic [7:0]       food_x, food_y;
  logic             food_valid;
  logic [7:0]       head_x, head_y;
  logic [PTR_W:0]   length;
  logic [PTR_W-1:0] tail_ptr, head_ptr;
  logic             food_eaten, dead, busy, tick_overrun;

  snake_step_ctrl_if #(.PTR_W(PTR_W)) bus ();

  snake_step_ctrl #(
    .COLS(80), .ROWS(60), .BODYMAX(64), .PTR_W(PTR_W)
  ) dut (
    .VGA_CLK      (VGA_CLK),
    .RST_N        (RST_N),
    .run_en       (run_en),
    .step_tick    (step_tick),
    .dir          (dir),
    .food_x       (food_x),
    .food_y       (food_y),
    .food_valid   (food_valid),
    .ram          (bus),
    .head_x       (head_x),
    .head_y       (head_y),
    .length       (length),
    .tail_ptr     (tail_ptr),
    .head_ptr     (head_ptr),
    .food_eaten   (food_eaten),
    .dead         (dead),
    .busy         (busy),
    .tick_overrun (tick_overrun)
  );

  always #20 VGA_CLK = ~VGA_CLK;

  // Body RAM model: synchronous read, one-cycle latency; counts writes.
  logic [15:0] mem [64];
  int          n_writes = 0;

  always @(posedge VGA_CLK) begin
    if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
      n_writes = n_writes + 1;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  int cyc, fe;

  // One tick, then wait until busy drops. cyc counts falling edges after the
  // tick edge up to the first idle one; fe counts food_eaten samples.
  task automatic step(input logic [1:0] d);
    @(negedge VGA_CLK);
    dir       = d;
    step_tick = 1'b1;
    cyc = 0;
    fe  = 0;
    do begin
      @(negedge VGA_CLK);
      step_tick = 1'b0;
      cyc++;
      fe += int'(food_eaten);
    end while (busy && cyc < 200);
    if (busy) check("step_timeout", 32'(busy), 32'd0);
  endtask

  task automatic eat_step(input logic [1:0] d, input logic [7:0] fx, input logic [7:0] fy);
    food_x     = fx;
    food_y     = fy;
    food_valid = 1'b1;
    step(d);
    food_valid = 1'b0;
  endtask

  task automatic reinit();
    @(negedge VGA_CLK);
    run_en     = 1'b0;
    food_valid = 1'b0;
    @(negedge VGA_CLK);
    @(negedge VGA_CLK);
    run_en = 1'b1;
    @(negedge VGA_CLK);
    @(negedge VGA_CLK);
  endtask

  function automatic logic [31:0] hd();
    return {16'd0, head_x, head_y};
  endfunction

  // Hard stop if something wedges.
  initial begin
    repeat (60000) @(posedge VGA_CLK);
    $display("FAIL watchdog: cycle budget expired");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int w0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    bus.ram_rdata = 16'h0000;
    RST_N      = 1'b0;
    run_en     = 1'b1;
    step_tick  = 1'b0;
    dir        = 2'd0;
    food_x     = 8'd0;
    food_y     = 8'd0;
    food_valid = 1'b0;

    // Reset values
    repeat (3) @(negedge VGA_CLK);
    check("rst_busy",   32'(busy), 32'd1);
    check("rst_head",   hd(), 32'h281E);
    check("rst_len",    32'(length), 32'd1);
    check("rst_ptrs",   {head_ptr, tail_ptr}, 32'd0);
    check("rst_flags",  {dead, food_eaten, tick_overrun, bus.ram_we}, 32'd0);
    check("rst_bus",    {bus.ram_addr, bus.ram_wdata}, 32'd0);

    // INIT: one cycle, writes {40,30} to address 0
    RST_N = 1'b1;
    @(negedge VGA_CLK);
    check("init_busy",  32'(busy), 32'd0);
    check("init_we",    {bus.ram_we, bus.ram_addr, bus.ram_wdata}, {1'b1, 6'd0, 16'h281E});
    @(negedge VGA_CLK);
    check("init_nwr",   32'(n_writes), 32'd1);
    check("init_mem0",  32'(mem[0]), 32'h281E);

    // Plain step +x, length 1
    step(2'd0);
    check("s1_lat",     32'(cyc), 32'd3);
    check("s1_head",    hd(), 32'h291E);
    check("s1_ptrs",    {head_ptr, tail_ptr}, {6'd1, 6'd1});
    check("s1_len",     32'(length), 32'd1);
    @(negedge VGA_CLK);
    check("s1_mem1",    32'(mem[1]), 32'h291E);
    check("s1_nwr",     32'(n_writes), 32'd2);

    // Eat from home
    reinit();
    check("ri_head",    hd(), 32'h281E);
    eat_step(2'd0, 8'd41, 8'd30);
    check("eat_pulse",  32'(fe), 32'd1);
    check("eat_lat",    32'(cyc), 32'd4);
    check("eat_len",    32'(length), 32'd2);
    check("eat_ptrs",   {head_ptr, tail_ptr}, {6'd1, 6'd0});
    step(2'd0);
    check("noeat_pulse", 32'(fe), 32'd0);
    step(2'd0);
    step(2'd0);
    check("run_head",   hd(), 32'h2C1E);
    check("run_len",    32'(length), 32'd2);
    check("run_ptrs",   {head_ptr, tail_ptr}, {6'd4, 6'd3});

    // U-shape of length 5 then turn into the body
    reinit();
    eat_step(2'd0, 8'd41, 8'd30);
    eat_step(2'd0, 8'd42, 8'd30);
    eat_step(2'd1, 8'd42, 8'd31);
    eat_step(2'd2, 8'd41, 8'd31);
    check("u_len",      32'(length), 32'd5);
    check("u_head",     hd(), 32'h291F);
    @(negedge VGA_CLK);
    w0 = n_writes;
    step(2'd3);
    check("u_dead",     32'(dead), 32'd1);
    check("u_busy",     32'(busy), 32'd0);
    check("u_nowr",     32'(n_writes), 32'(w0));
    check("u_head2",    hd(), 32'h291F);
    step(2'd0);
    check("u_ign_head", hd(), 32'h291F);
    check("u_ign_wr",   32'(n_writes), 32'(w0));
    check("u_ign_flag", {dead, tick_overrun}, 32'b10);
    reinit();
    check("u_re_len",   32'(length), 32'd1);
    check("u_re_dead",  32'(dead), 32'd0);
    check("u_re_ptrs",  {head_ptr, tail_ptr}, 32'd0);

    // Square of length 4: moving into the vacating tail is legal,
    // reversing into the neck is not.
    reinit();
    eat_step(2'd1, 8'd40, 8'd31);
    eat_step(2'd0, 8'd41, 8'd31);
    eat_step(2'd3, 8'd41, 8'd30);
    step(2'd2);
    check("sq_alive",   32'(dead), 32'd0);
    check("sq_head",    hd(), 32'h281E);
    check("sq_state",   {length, head_ptr, tail_ptr}, {7'd4, 6'd4, 6'd1});
    step(2'd0);
    check("sq_neck",    32'(dead), 32'd1);

    // Right edge
    reinit();
    for (int i = 0; i < 39; i++) step(2'd0);
    check("edge_head",  hd(), 32'h4F1E);
    check("edge_hp",    32'(head_ptr), 32'd39);
    @(negedge VGA_CLK);
    w0 = n_writes;
    step(2'd0);
`ifdef SNAKE_WRAP_EN
    check("wrap_head",  hd(), 32'h001E);
    check("wrap_dead",  32'(dead), 32'd0);
    @(negedge VGA_CLK);
    check("wrap_wr",    32'(n_writes), 32'(w0 + 1));
`else
    check("edge_dead",  32'(dead), 32'd1);
    check("edge_lat",   32'(cyc), 32'd1);
    check("edge_hold",  hd(), 32'h4F1E);
    @(negedge VGA_CLK);
    check("edge_nowr",  32'(n_writes), 32'(w0));
`endif

    // Overrun: second tick 2 cycles after the first at length 4
    reinit();
    eat_step(2'd0, 8'd41, 8'd30);
    eat_step(2'd0, 8'd42, 8'd30);
    eat_step(2'd0, 8'd43, 8'd30);
    check("ov_len",     32'(length), 32'd4);
    check("ov_pre",     32'(tick_overrun), 32'd0);
    @(negedge VGA_CLK);
    w0 = n_writes;
    dir       = 2'd0;
    step_tick = 1'b1;
    @(negedge VGA_CLK);
    step_tick = 1'b0;
    @(negedge VGA_CLK);
    step_tick = 1'b1;
    @(negedge VGA_CLK);
    step_tick = 1'b0;
    repeat (20) @(negedge VGA_CLK);
    check("ov_flag",    32'(tick_overrun), 32'd1);
    check("ov_head",    hd(), 32'h2C1E);
    check("ov_wr",      32'(n_writes), 32'(w0 + 1));
    check("ov_idle",    {busy, dead}, 32'd0);
    check("ov_ptrs",    {head_ptr, tail_ptr}, {6'd4, 6'd1});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
